// File: rtl/coin_ledger_pkg.sv
// ============================================================================
// Module      : coin_pkg
// Description : Shared coin indices, coin values and ledger state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package coin_pkg;

    localparam int NUM_COINS = 4;

    localparam int NICKEL  = 0;
    localparam int DIME    = 1;
    localparam int QUARTER = 2;
    localparam int DOLLAR  = 3;

    // Cent value of each coin, indexed by the coin constants above.
    localparam int unsigned COIN_VALUE [NUM_COINS] = '{5, 10, 25, 100};

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DISPENSE = 2'd1,
        ST_DONE     = 2'd2
    } ledger_state_t;

endpackage

`default_nettype wire

// File: rtl/coin_ledger_if.sv
// ============================================================================
// Module      : coin_ledger_if
// Description : Coin, purchase and change-dispensing signals of the ledger.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface coin_ledger_if #(
    parameter int BAL_W = 9
);
    logic [3:0]       coin_in;
    logic             vend_valid;
    logic [BAL_W-1:0] vend_price;
    logic             vend_ready;
    logic             vend_ok;
    logic             vend_deny;
    logic             refund_req;
    logic             change_valid;
    logic [3:0]       change_coin;
    logic             change_ready;
    logic             refund_done;
    logic             coin_reject;
    logic [BAL_W-1:0] balance;
    logic             busy;

    modport master (
        output coin_in, vend_valid, vend_price, refund_req, change_ready,
        input  vend_ready, vend_ok, vend_deny, change_valid, change_coin,
               refund_done, coin_reject, balance, busy
    );

    modport slave (
        input  coin_in, vend_valid, vend_price, refund_req, change_ready,
        output vend_ready, vend_ok, vend_deny, change_valid, change_coin,
               refund_done, coin_reject, balance, busy
    );
endinterface

`default_nettype wire

// File: rtl/coin_ledger_change_picker.sv
// ============================================================================
// Module      : change_picker
// Description : Greedy largest-coin selection for a given balance.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module change_picker
    import coin_pkg::*;
#(
    parameter int BAL_W = 9
) (
    input  wire logic [BAL_W-1:0] balance_i,
    output logic      [3:0]       coin_o,
    output logic      [BAL_W-1:0] value_o
);

    // Ascending scan: the last coin that fits is the largest one.
    always_comb begin
        coin_o  = '0;
        value_o = '0;
        for (int i = 0; i < NUM_COINS; i++) begin
            if (balance_i >= BAL_W'(COIN_VALUE[i])) begin
                coin_o    = '0;
                coin_o[i] = 1'b1;
                value_o   = BAL_W'(COIN_VALUE[i]);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/coin_ledger.sv
// ============================================================================
// Module      : coin_ledger
// Description : Saturating credit ledger with purchase handshake and refund.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module coin_ledger
    import coin_pkg::*;
#(
    parameter int BAL_W   = 9,
    parameter int MAX_BAL = 400
) (
    input  wire logic    clk,
    input  wire logic    reset,
    coin_ledger_if.slave lg
);

    localparam int               EXT_W  = BAL_W + 2;
    localparam logic [BAL_W-1:0] c_FIVE = BAL_W'(5);

    ledger_state_t    state_q, state_d;
    logic [BAL_W-1:0] balance_q, balance_d;
    logic             vend_ready_q, vend_ready_d;
    logic             vend_ok_q, vend_ok_d;
    logic             vend_deny_q, vend_deny_d;
    logic             coin_reject_q, coin_reject_d;

    logic [EXT_W-1:0] w_deposit;
    logic [EXT_W-1:0] w_candidate;
    logic [BAL_W-1:0] w_debit;
    logic             w_fire;
    logic             w_price_ok;
    logic [3:0]       w_pick_coin;
    logic [BAL_W-1:0] w_pick_value;
    logic             w_offer;

    change_picker #(
        .BAL_W (BAL_W)
    ) u_picker (
        .balance_i (balance_q),
        .coin_o    (w_pick_coin),
        .value_o   (w_pick_value)
    );

    always_comb begin
        w_deposit = '0;
        for (int i = 0; i < NUM_COINS; i++) begin
            if (lg.coin_in[i]) begin
                w_deposit = w_deposit + EXT_W'(COIN_VALUE[i]);
            end
        end
    end

    // Price is judged against the balance before this cycle's deposit.
    assign w_fire      = lg.vend_valid && vend_ready_q;
    assign w_price_ok  = (lg.vend_price <= balance_q)
                      && ((lg.vend_price % c_FIVE) == '0)
                      && (lg.vend_price != '0);
    assign w_debit     = (w_fire && w_price_ok) ? lg.vend_price : '0;
    assign w_candidate = EXT_W'(balance_q) - EXT_W'(w_debit) + w_deposit;
    assign w_offer     = (state_q == ST_DISPENSE) && (balance_q != '0);

    always_comb begin
        state_d       = state_q;
        balance_d     = balance_q;
        vend_ok_d     = 1'b0;
        vend_deny_d   = 1'b0;
        coin_reject_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (lg.refund_req) begin
                    state_d       = ST_DISPENSE;
                    vend_deny_d   = w_fire;
                    coin_reject_d = |lg.coin_in;
                end else begin
                    vend_ok_d   = w_fire && w_price_ok;
                    vend_deny_d = w_fire && !w_price_ok;
                    if (w_candidate > EXT_W'(MAX_BAL)) begin
                        coin_reject_d = 1'b1;
                        balance_d     = balance_q - w_debit;
                    end else begin
                        balance_d = w_candidate[BAL_W-1:0];
                    end
                end
            end
            ST_DISPENSE: begin
                coin_reject_d = |lg.coin_in;
                if (balance_q == '0) begin
                    state_d = ST_DONE;
                end else if (lg.change_ready) begin
                    balance_d = balance_q - w_pick_value;
                end
            end
            ST_DONE: begin
                coin_reject_d = |lg.coin_in;
                state_d       = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        vend_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            balance_q     <= '0;
            vend_ready_q  <= 1'b1;
            vend_ok_q     <= 1'b0;
            vend_deny_q   <= 1'b0;
            coin_reject_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            balance_q     <= balance_d;
            vend_ready_q  <= vend_ready_d;
            vend_ok_q     <= vend_ok_d;
            vend_deny_q   <= vend_deny_d;
            coin_reject_q <= coin_reject_d;
        end
    end

    assign lg.vend_ready   = vend_ready_q;
    assign lg.vend_ok      = vend_ok_q;
    assign lg.vend_deny    = vend_deny_q;
    assign lg.coin_reject  = coin_reject_q;
    assign lg.balance      = balance_q;
    assign lg.change_valid = w_offer;
    assign lg.change_coin  = w_offer ? w_pick_coin : 4'b0000;
    assign lg.refund_done  = (state_q == ST_DONE);
    assign lg.busy         = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_coin_ledger.sv
// ============================================================================
// Module      : tb_coin_ledger
// Description : Self-checking scoreboard bench for coin_ledger.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_coin_ledger;

    localparam int BAL_W = 9;

    localparam logic [3:0] N = 4'b0001;
    localparam logic [3:0] D = 4'b0010;
    localparam logic [3:0] Q = 4'b0100;
    localparam logic [3:0] B = 4'b1000;

    typedef struct {
        string tag;
        int    bal;
        int    ok;
        int    deny;
        int    rej;
    } exp_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    exp_t sb[$];

    coin_ledger_if #(.BAL_W(BAL_W)) lg ();

    coin_ledger #(
        .BAL_W   (BAL_W),
        .MAX_BAL (400)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .lg    (lg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        lg.coin_in      = '0;
        lg.vend_valid   = 1'b0;
        lg.vend_price   = '0;
        lg.refund_req   = 1'b0;
        lg.change_ready = 1'b0;
    endtask

    // Drive one cycle of stimulus, queue its expected result, then score it.
    task automatic cyc(input logic [3:0] c, input logic vv, input int p,
                       input logic rf, input logic cr, input string tag,
                       input int eb, input int eok, input int edn, input int erej);
        exp_t e;
        @(negedge clk);
        lg.coin_in      = c;
        lg.vend_valid   = vv;
        lg.vend_price   = BAL_W'(p);
        lg.refund_req   = rf;
        lg.change_ready = cr;
        sb.push_back('{tag, eb, eok, edn, erej});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            chk({e.tag, "_bal"},  int'(lg.balance),     e.bal);
            chk({e.tag, "_ok"},   int'(lg.vend_ok),     e.ok);
            chk({e.tag, "_deny"}, int'(lg.vend_deny),   e.deny);
            chk({e.tag, "_rej"},  int'(lg.coin_reject), e.rej);
        end
        clear_inputs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        clear_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_bal",    int'(lg.balance),      0);
        chk("rst_busy",   int'(lg.busy),         0);
        chk("rst_cvalid", int'(lg.change_valid), 0);
        chk("rst_ccoin",  int'(lg.change_coin),  0);
        chk("rst_ok",     int'(lg.vend_ok),      0);
        chk("rst_done",   int'(lg.refund_done),  0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_ready", int'(lg.vend_ready), 1);

        // Deposit sums and a purchase
        cyc(Q,     0, 0,   0, 0, "dep_q",   25,  0, 0, 0);
        cyc(B | D, 0, 0,   0, 0, "dep_bd",  135, 0, 0, 0);
        cyc('0,    1, 125, 0, 0, "buy125",  10,  1, 0, 0);

        // Deposit overflow
        cyc(B, 0, 0, 0, 0, "fill1", 110, 0, 0, 0);
        cyc(B, 0, 0, 0, 0, "fill2", 210, 0, 0, 0);
        cyc(B, 0, 0, 0, 0, "fill3", 310, 0, 0, 0);
        cyc(Q, 0, 0, 0, 0, "fill4", 335, 0, 0, 0);
        cyc(D, 0, 0, 0, 0, "fill5", 345, 0, 0, 0);
        cyc(N, 0, 0, 0, 0, "fill6", 350, 0, 0, 0);
        cyc(B,     0, 0, 0, 0, "ovf",    350, 0, 0, 1);
        cyc(N | Q, 0, 0, 0, 0, "dep_nq", 380, 0, 0, 0);

        // Purchase and deposit together; price corner cases
        cyc('0, 1, 330, 0, 0, "buy330",   50, 1, 0, 0);
        cyc(Q,  1, 75,  0, 0, "buy75_q",  75, 0, 1, 0);
        cyc('0, 1, 57,  0, 0, "buy57",    75, 0, 1, 0);
        cyc('0, 1, 0,   0, 0, "buy0",     75, 0, 1, 0);
        cyc('0, 1, 75,  0, 0, "buy_all",  0,  1, 0, 0);
        cyc(B | Q | D | N, 0, 0, 0, 0, "dep_all", 140, 0, 0, 0);

        // Refund with a stalled dispenser
        cyc('0, 0, 0, 1, 0, "refund", 140, 0, 0, 0);
        chk("disp_ready", int'(lg.vend_ready),   0);
        chk("disp_busy",  int'(lg.busy),         1);
        chk("offer0_v",   int'(lg.change_valid), 1);
        chk("offer0_c",   int'(lg.change_coin),  int'(B));
        cyc('0, 0, 0, 0, 0, "stall1", 140, 0, 0, 0);
        chk("stall1_c", int'(lg.change_coin), int'(B));
        cyc(Q,  0, 0, 0, 0, "stall2_coin", 140, 0, 0, 1);
        chk("stall2_c", int'(lg.change_coin), int'(B));
        cyc('0, 1, 5, 1, 0, "stall3_vend", 140, 0, 0, 0);
        chk("stall3_c", int'(lg.change_coin), int'(B));
        cyc('0, 0, 0, 0, 1, "give_b", 40, 0, 0, 0);
        chk("offer1_c", int'(lg.change_coin), int'(Q));
        cyc('0, 0, 0, 0, 1, "give_q", 15, 0, 0, 0);
        chk("offer2_c", int'(lg.change_coin), int'(D));
        cyc('0, 0, 0, 0, 1, "give_d", 5, 0, 0, 0);
        chk("offer3_c", int'(lg.change_coin), int'(N));
        cyc('0, 0, 0, 0, 1, "give_n", 0, 0, 0, 0);
        chk("empty_v",    int'(lg.change_valid), 0);
        chk("empty_done", int'(lg.refund_done),  0);
        cyc('0, 0, 0, 0, 0, "to_done", 0, 0, 0, 0);
        chk("done_pulse", int'(lg.refund_done), 1);
        cyc('0, 0, 0, 0, 0, "to_idle", 0, 0, 0, 0);
        chk("idle_done",  int'(lg.refund_done), 0);
        chk("idle_ready", int'(lg.vend_ready),  1);

        // Asynchronous reset in the middle of a refund
        cyc(Q | D, 0, 0, 0, 0, "dep35",  35, 0, 0, 0);
        cyc('0,    0, 0, 1, 0, "ref35",  35, 0, 0, 0);
        chk("ref35_c", int'(lg.change_coin), int'(Q));
        #1;
        reset = 1'b1;
        #1;
        chk("arst_bal",  int'(lg.balance),      0);
        chk("arst_v",    int'(lg.change_valid), 0);
        chk("arst_c",    int'(lg.change_coin),  0);
        chk("arst_busy", int'(lg.busy),         0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("arst_ready", int'(lg.vend_ready), 1);
        chk("arst_bal2",  int'(lg.balance),    0);

        // Zero-balance refund, with a same-cycle purchase and coin
        cyc(N, 1, 5, 1, 0, "ref0", 0, 0, 1, 1);
        chk("ref0_v",     int'(lg.change_valid), 0);
        chk("ref0_done1", int'(lg.refund_done),  0);
        cyc('0, 0, 0, 0, 1, "ref0_c2", 0, 0, 0, 0);
        chk("ref0_v2",    int'(lg.change_valid), 0);
        chk("ref0_done2", int'(lg.refund_done),  1);
        cyc('0, 0, 0, 0, 0, "ref0_c3", 0, 0, 0, 0);
        chk("ref0_done3", int'(lg.refund_done), 0);
        chk("ref0_busy",  int'(lg.busy),        0);

        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
